// File: rtl/mem_stage_unit_if.sv
// EX/MEM -> MEM/WB bus of the memory stage.
// The DUT takes the slave side; the pipeline (or a bench) drives the master side.
interface mem_stage_unit_if;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] Address_in;
  logic [31:0] WriteData_in;
  logic [4:0]  Rd_in;
  logic        Stall_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic [31:0] ReadData_out;
  logic [31:0] ALUResult_out;
  logic [4:0]  Rd_out;
  logic        Misalign_out;

  modport slave (
    input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
    input  Address_in, WriteData_in, Rd_in,
    output Stall_out, RegWrite_out, MemtoReg_out, ReadData_out,
    output ALUResult_out, Rd_out, Misalign_out
  );

  modport master (
    output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
    output Address_in, WriteData_in, Rd_in,
    input  Stall_out, RegWrite_out, MemtoReg_out, ReadData_out,
    input  ALUResult_out, Rd_out, Misalign_out
  );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: word-addressed data memory with a fixed number of wait
// cycles before each aligned access, stall generation and MEM/WB register.
module mem_stage_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  mem_stage_unit_if.slave bus
);
  localparam int            CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     ctr, ctr_nxt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              acc_req, mem_op, misal;
  logic              stall, access, wr_en;

  // Request decode; upper address bits are dropped so accesses wrap.
  always_comb begin
    acc_req = bus.MemRead_in | bus.MemWrite_in;
    mem_op  = acc_req && (bus.Address_in[1:0] == 2'b00);
    misal   = acc_req && (bus.Address_in[1:0] != 2'b00);
    idx     = bus.Address_in[ADDR_W+1:2];
  end

  // Wait-state sequencing: decide stall / access and next state.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    stall     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (WAIT_CYCLES == 0) begin
            access = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
            ctr_nxt   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (ctr < WC) begin
          stall   = 1'b1;
          ctr_nxt = ctr + 1'b1;
        end else begin
          access    = 1'b1;
          state_nxt = IDLE;
          ctr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ctr_nxt   = '0;
      end
    endcase
  end

  // Reset has to silence the combinational stall and block any write at once.
  always_comb begin
    bus.Stall_out = stall & RST_N;
    wr_en         = access & bus.MemWrite_in & RST_N;
  end

  // State and wait counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  // Data memory array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[idx] <= bus.WriteData_in;
  end

  // MEM/WB register: bubble while stalled, result on access, pass-through otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.RegWrite_out  <= 1'b0;
      bus.MemtoReg_out  <= 1'b0;
      bus.ReadData_out  <= '0;
      bus.ALUResult_out <= '0;
      bus.Rd_out        <= '0;
      bus.Misalign_out  <= 1'b0;
    end else if (stall) begin
      bus.RegWrite_out  <= 1'b0;
      bus.MemtoReg_out  <= 1'b0;
      bus.ReadData_out  <= '0;
      bus.ALUResult_out <= '0;
      bus.Rd_out        <= '0;
      bus.Misalign_out  <= 1'b0;
    end else if (access) begin
      bus.RegWrite_out  <= bus.RegWrite_in;
      bus.MemtoReg_out  <= bus.MemtoReg_in;
      // A combined read+write is a pure write, so no load data.
      bus.ReadData_out  <= bus.MemWrite_in ? 32'h0 : mem[idx];
      bus.ALUResult_out <= bus.Address_in;
      bus.Rd_out        <= bus.Rd_in;
      bus.Misalign_out  <= 1'b0;
    end else begin
      // Misaligned requests are dropped: no register writeback, flag pulsed.
      bus.RegWrite_out  <= bus.RegWrite_in & ~misal;
      bus.MemtoReg_out  <= bus.MemtoReg_in;
      bus.ReadData_out  <= '0;
      bus.ALUResult_out <= bus.Address_in;
      bus.Rd_out        <= bus.Rd_in;
      bus.Misalign_out  <= misal;
    end
  end
endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed scenarios plus random ops against a
// transaction-level memory model (word array indexed by address modulo depth).
module tb_mem_stage_unit;
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mem_stage_unit_if b2 ();
  mem_stage_unit_if b0 ();

  mem_stage_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut  (.CLK(CLK), .RST_N(RST_N), .bus(b2));
  mem_stage_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(b0));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [256];
  bit          vld [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive2(input bit rd_en, input bit wr_en, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rdst,
                        input bit rw, input bit m2r);
    b2.MemRead_in   = rd_en;
    b2.MemWrite_in  = wr_en;
    b2.Address_in   = a;
    b2.WriteData_in = wd;
    b2.Rd_in        = rdst;
    b2.RegWrite_in  = rw;
    b2.MemtoReg_in  = m2r;
  endtask

  // One complete op on the WAIT_CYCLES=2 unit, checked against the model.
  task automatic op(input bit rd_en, input bit wr_en, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] rdst,
                    input bit rw, input bit m2r);
    int          nst;
    bit          mop, mis, is_rd;
    logic [7:0]  i;
    logic [31:0] exp_rd;
    mop   = (rd_en | wr_en) && (a[1:0] == 2'b00);
    mis   = (rd_en | wr_en) && (a[1:0] != 2'b00);
    is_rd = mop && rd_en && !wr_en;
    i     = a[9:2];
    drive2(rd_en, wr_en, a, wd, rdst, rw, m2r);
    #1;
    nst = 0;
    while (b2.Stall_out && nst < 10) begin
      @(posedge CLK); #1;
      nst++;
      chk("bubble_regwrite", {31'b0, b2.RegWrite_out}, 32'h0);
      chk("bubble_alu", b2.ALUResult_out, 32'h0);
    end
    chk("stall_cycles", 32'(nst), mop ? 32'd2 : 32'd0);
    @(posedge CLK); #1;
    chk("regwrite", {31'b0, b2.RegWrite_out}, {31'b0, rw & ~mis});
    chk("memtoreg", {31'b0, b2.MemtoReg_out}, {31'b0, m2r});
    chk("alu_result", b2.ALUResult_out, a);
    chk("rd", {27'b0, b2.Rd_out}, {27'b0, rdst});
    chk("misalign", {31'b0, b2.Misalign_out}, {31'b0, mis});
    chk("stall_after", {31'b0, b2.Stall_out}, {31'b0, mop});
    exp_rd = is_rd ? mdl[i] : 32'h0;
    if (!is_rd || vld[i]) chk("read_data", b2.ReadData_out, exp_rd);
    if (mop && wr_en) begin
      mdl[i] = wd;
      vld[i] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    bit          r, w;
    for (int k = 0; k < 256; k++) vld[k] = 1'b0;
    drive2(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    b0.MemRead_in = 0; b0.MemWrite_in = 0; b0.Address_in = '0;
    b0.WriteData_in = '0; b0.Rd_in = '0; b0.RegWrite_in = 0; b0.MemtoReg_in = 0;

    // Reset state
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2;
    chk("rst_stall", {31'b0, b2.Stall_out}, 32'h0);
    chk("rst_regwrite", {31'b0, b2.RegWrite_out}, 32'h0);
    chk("rst_alu", b2.ALUResult_out, 32'h0);
    chk("rst_rdata", b2.ReadData_out, 32'h0);
    chk("rst_misalign", {31'b0, b2.Misalign_out}, 32'h0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;

    // Store then load with full wait sequence
    op(0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
    op(1, 0, 32'h10, 32'h0, 5'd5, 1, 1);
    // R-type pass-through
    op(0, 0, 32'h1234, 32'h0, 5'd7, 1, 0);
    // Misaligned read, then misaligned write to the same word; memory untouched
    op(1, 0, 32'h12, 32'h0, 5'd3, 1, 1);
    op(0, 1, 32'h12, 32'h55, 5'd4, 1, 0);
    op(1, 0, 32'h10, 32'h0, 5'd6, 1, 1);
    // Wrap-around of the word index
    op(0, 1, 32'h400, 32'hA5, 5'd0, 0, 0);
    op(1, 0, 32'h000, 32'h0, 5'd8, 1, 1);
    // Read+write together is a write
    op(1, 1, 32'h24, 32'h0BADF00D, 5'd2, 0, 0);
    op(1, 0, 32'h24, 32'h0, 5'd2, 1, 1);

    // Reset in the middle of a write
    op(0, 1, 32'h20, 32'h11112222, 5'd0, 0, 0);
    drive2(0, 1, 32'h20, 32'h99999999, 5'd1, 1, 0);
    #1;
    @(posedge CLK); #1;
    chk("mid_wait_stall", {31'b0, b2.Stall_out}, 32'h1);
    RST_N = 1'b0;
    #1;
    chk("abort_stall", {31'b0, b2.Stall_out}, 32'h0);
    chk("abort_regwrite", {31'b0, b2.RegWrite_out}, 32'h0);
    chk("abort_rdata", b2.ReadData_out, 32'h0);
    chk("abort_alu", b2.ALUResult_out, 32'h0);
    chk("abort_rd", {27'b0, b2.Rd_out}, 32'h0);
    drive2(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    op(1, 0, 32'h20, 32'h0, 5'd9, 1, 1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      op(r, w, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
    end
    drive2(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);

    // Zero-wait unit: read+write completes as a write in one cycle
    b0.MemRead_in = 1; b0.MemWrite_in = 1; b0.Address_in = 32'h40;
    b0.WriteData_in = 32'hCAFEF00D; b0.Rd_in = 5'd9; b0.RegWrite_in = 1;
    #1;
    chk("w0_stall", {31'b0, b0.Stall_out}, 32'h0);
    @(posedge CLK); #1;
    chk("w0_rdata_write", b0.ReadData_out, 32'h0);
    chk("w0_rd", {27'b0, b0.Rd_out}, 32'd9);
    b0.MemWrite_in = 0;
    #1;
    chk("w0_stall_read", {31'b0, b0.Stall_out}, 32'h0);
    @(posedge CLK); #1;
    chk("w0_rdata_read", b0.ReadData_out, 32'hCAFEF00D);
    b0.MemRead_in = 0;
    @(posedge CLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
